// File: rtl/pipeline_hazard_controller.sv
// Purpose : stall/flush sequencer for load-use, taken-branch and multi-cycle mul/div hazards.
// Latency : control outputs are combinational from inputs and state (same-cycle action).
// Backpressure: holds PC/IF/ID/ID/EX for load-use (1 cycle) and mul/div (MULDIV_LATENCY-1 cycles).
//
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   id_* / ex_*             hazard sources from the ID and EX stages
//   pc_write, *_write       pipeline register enables
//   *_flush                 pipeline register bubble/NOP inserts
//   muldiv_busy             mul/div occupancy in progress
//   muldiv_result_valid     final mul/div cycle, EX result may be latched
//   stall_cycles            saturating count of cycles with pc_write=0
//   flush_events            saturating count of cycles with if_id_flush=1
module pipeline_hazard_controller #(
   parameter int unsigned MULDIV_LATENCY = 4,   // legal 2..16
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           id_rs1_addr,
   input  logic [4:0]           id_rs2_addr,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic [4:0]           ex_rd_addr,
   input  logic                 ex_mem_read,
   input  logic                 ex_branch_taken,
   input  logic                 ex_muldiv_valid,
   output logic                 pc_write,
   output logic                 if_id_write,
   output logic                 if_id_flush,
   output logic                 id_ex_write,
   output logic                 id_ex_flush,
   output logic                 ex_mem_flush,
   output logic                 muldiv_busy,
   output logic                 muldiv_result_valid,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_events
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   // The first mul/div cycle is spent in IDLE, the last one at cnt==0,
   // so BUSY is entered with LATENCY-2 cycles still to hold.
   localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LATENCY - 2);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       load_use;

   // x0 is hard-wired zero, so a load targeting it never creates a hazard.
   assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                      (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt           = state;
      cnt_nxt             = cnt;
      pc_write            = 1'b1;
      if_id_write         = 1'b1;
      if_id_flush         = 1'b0;
      id_ex_write         = 1'b1;
      id_ex_flush         = 1'b0;
      ex_mem_flush        = 1'b0;
      muldiv_busy         = 1'b0;
      muldiv_result_valid = 1'b0;

      // Reset forces the idle output values irrespective of the inputs.
      if (!reset) begin
         case (state)
            S_IDLE: begin
               if (ex_branch_taken) begin
                  // Branch wins over a concurrent mul/div (decode keeps them exclusive).
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (ex_muldiv_valid) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_write  = 1'b0;
                  ex_mem_flush = 1'b1;
                  state_nxt    = S_BUSY;
                  cnt_nxt      = CNT_LOAD;
               end else if (load_use) begin
                  // The load moves on to MEM, so one bubble resolves it.
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
            S_BUSY: begin
               muldiv_busy = 1'b1;
               if (cnt != 4'd0) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_write  = 1'b0;
                  ex_mem_flush = 1'b1;
                  cnt_nxt      = cnt - 4'd1;
               end else begin
                  muldiv_result_valid = 1'b1;
                  state_nxt           = S_IDLE;
               end
            end
            default: begin
               state_nxt = S_IDLE;
               cnt_nxt   = 4'd0;
            end
         endcase
      end
   end

   // Performance counters saturate at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!pc_write && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_ONE;
         if (if_id_flush && (flush_events != '1))
            flush_events <= flush_events + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: two instances share stimulus,
// one with MULDIV_LATENCY=4/CNT_WIDTH=4 and one with MULDIV_LATENCY=2/CNT_WIDTH=8.
// Control outputs are packed {pc_w, ifid_w, ifid_fl, idex_w, idex_fl, exmem_fl, busy, rvalid}.
module tb_pipeline_hazard_controller;

   localparam logic [7:0] C_IDLE = 8'hD0;  // 1101_0000
   localparam logic [7:0] C_LU   = 8'h18;  // 0001_1000
   localparam logic [7:0] C_BR   = 8'hF8;  // 1111_1000
   localparam logic [7:0] C_MD0  = 8'h04;  // 0000_0100  mul/div start from IDLE
   localparam logic [7:0] C_MDB  = 8'h06;  // 0000_0110  BUSY hold
   localparam logic [7:0] C_MDR  = 8'hD3;  // 1101_0011  BUSY release

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_muldiv_valid;

   logic       pc_write_a, if_id_write_a, if_id_flush_a, id_ex_write_a, id_ex_flush_a;
   logic       ex_mem_flush_a, muldiv_busy_a, muldiv_result_valid_a;
   logic [3:0] stall_cycles_a, flush_events_a;
   logic       pc_write_b, if_id_write_b, if_id_flush_b, id_ex_write_b, id_ex_flush_b;
   logic       ex_mem_flush_b, muldiv_busy_b, muldiv_result_valid_b;
   logic [7:0] stall_cycles_b, flush_events_b;
   logic [7:0] ctl_a, ctl_b;

   int checks   = 0;
   int failures = 0;
   int pulses_a = 0;
   int pulses_b = 0;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.MULDIV_LATENCY(4), .CNT_WIDTH(4)) u_dut_a (
      .clk(clk), .reset(reset),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .ex_muldiv_valid(ex_muldiv_valid),
      .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_id_flush(if_id_flush_a),
      .id_ex_write(id_ex_write_a), .id_ex_flush(id_ex_flush_a), .ex_mem_flush(ex_mem_flush_a),
      .muldiv_busy(muldiv_busy_a), .muldiv_result_valid(muldiv_result_valid_a),
      .stall_cycles(stall_cycles_a), .flush_events(flush_events_a)
   );

   pipeline_hazard_controller #(.MULDIV_LATENCY(2), .CNT_WIDTH(8)) u_dut_b (
      .clk(clk), .reset(reset),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .ex_muldiv_valid(ex_muldiv_valid),
      .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_id_flush(if_id_flush_b),
      .id_ex_write(id_ex_write_b), .id_ex_flush(id_ex_flush_b), .ex_mem_flush(ex_mem_flush_b),
      .muldiv_busy(muldiv_busy_b), .muldiv_result_valid(muldiv_result_valid_b),
      .stall_cycles(stall_cycles_b), .flush_events(flush_events_b)
   );

   assign ctl_a = {pc_write_a, if_id_write_a, if_id_flush_a, id_ex_write_a,
                   id_ex_flush_a, ex_mem_flush_a, muldiv_busy_a, muldiv_result_valid_a};
   assign ctl_b = {pc_write_b, if_id_write_b, if_id_flush_b, id_ex_write_b,
                   id_ex_flush_b, ex_mem_flush_b, muldiv_busy_b, muldiv_result_valid_b};

   // Result pulses counted on the sampling side of each clock edge.
   always @(posedge clk) begin
      if (!reset && muldiv_result_valid_a) pulses_a <= pulses_a + 1;
      if (!reset && muldiv_result_valid_b) pulses_b <= pulses_b + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd_addr = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_muldiv_valid = 1'b0;
   endtask

   task automatic set_load_use();
      ex_mem_read = 1'b1; ex_rd_addr = 5'd5;
      id_rs1_addr = 5'd3; id_uses_rs1 = 1'b1;
      id_rs2_addr = 5'd5; id_uses_rs2 = 1'b1;
   endtask

   // Called at a negedge with inputs already set: checks the combinational
   // outputs of instance A, then advances to the next negedge.
   task automatic cyc(input string tag, input logic [7:0] exp);
      #2;
      check_val(tag, {24'd0, ctl_a}, {24'd0, exp});
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      // Hazard inputs active during reset must not leak to the outputs.
      ex_branch_taken = 1'b1; ex_muldiv_valid = 1'b1; set_load_use();
      @(negedge clk);
      #2;
      check_val("rst_ctl",   {24'd0, ctl_a}, {24'd0, C_IDLE});
      check_val("rst_stall", {28'd0, stall_cycles_a}, 32'd0);
      check_val("rst_flush", {28'd0, flush_events_a}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();

      // Load-use on rs2: one stall cycle, then the load has moved on.
      set_load_use();
      cyc("lu_stall", C_LU);
      ex_mem_read = 1'b0;
      cyc("lu_release", C_IDLE);
      check_val("lu_stall_cnt", {28'd0, stall_cycles_a}, 32'd1);
      check_val("lu_flush_cnt", {28'd0, flush_events_a}, 32'd0);

      // Load-use through rs1 only.
      pulse_reset();
      ex_mem_read = 1'b1; ex_rd_addr = 5'd9; id_rs1_addr = 5'd9; id_uses_rs1 = 1'b1;
      cyc("lu_rs1", C_LU);

      // No false stalls: load to x0, and a matching but unused source.
      pulse_reset();
      ex_mem_read = 1'b1; ex_rd_addr = 5'd0;
      id_rs1_addr = 5'd0; id_uses_rs1 = 1'b1; id_rs2_addr = 5'd0; id_uses_rs2 = 1'b1;
      cyc("nf_x0", C_IDLE);
      ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_uses_rs1 = 1'b0;
      id_rs2_addr = 5'd8; id_uses_rs2 = 1'b1;
      cyc("nf_unused", C_IDLE);
      ex_mem_read = 1'b0; id_uses_rs1 = 1'b1;
      cyc("nf_noload", C_IDLE);
      check_val("nf_stall_cnt", {28'd0, stall_cycles_a}, 32'd0);
      check_val("nf_flush_cnt", {28'd0, flush_events_a}, 32'd0);

      // Branch wins over a concurrent load-use and mul/div.
      pulse_reset();
      set_load_use(); ex_branch_taken = 1'b1; ex_muldiv_valid = 1'b1;
      cyc("br", C_BR);
      idle_inputs();
      cyc("br_after", C_IDLE);
      check_val("br_flush_cnt", {28'd0, flush_events_a}, 32'd1);
      check_val("br_stall_cnt", {28'd0, stall_cycles_a}, 32'd0);

      // Two back-to-back mul/divs, valid held high for 8 cycles.
      // Latency 4: 04,06,06,D3 twice. Latency 2: 04,D3 four times.
      pulse_reset();
      pulses_a = 0; pulses_b = 0;
      ex_muldiv_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #2;
         check_val($sformatf("md4_c%0d", i), {24'd0, ctl_a},
                   {24'd0, (i % 4 == 0) ? C_MD0 : (i % 4 == 3) ? C_MDR : C_MDB});
         check_val($sformatf("md2_c%0d", i), {24'd0, ctl_b},
                   {24'd0, (i % 2 == 0) ? C_MD0 : C_MDR});
         if (i == 1) begin
            // Branch and load-use are ignored while BUSY.
            ex_branch_taken = 1'b1; set_load_use();
            #1;
            check_val("md_busy_ign", {24'd0, ctl_a}, {24'd0, C_MDB});
            ex_branch_taken = 1'b0; ex_mem_read = 1'b0;
         end
         @(negedge clk);
      end
      ex_muldiv_valid = 1'b0;
      cyc("md_done", C_IDLE);
      check_val("md4_stall_cnt", {28'd0, stall_cycles_a}, 32'd6);
      check_val("md2_stall_cnt", {24'd0, stall_cycles_b}, 32'd4);
      check_val("md4_pulses", pulses_a, 32'd2);
      check_val("md2_pulses", pulses_b, 32'd4);
      check_val("md_flush_cnt", {28'd0, flush_events_a}, 32'd0);

      // Reset asserted on the second BUSY cycle.
      pulse_reset();
      ex_muldiv_valid = 1'b1;
      cyc("mr_start", C_MD0);
      cyc("mr_busy1", C_MDB);
      #2;
      check_val("mr_busy2", {24'd0, ctl_a}, {24'd0, C_MDB});
      check_val("mr_pre_stall", {28'd0, stall_cycles_a}, 32'd2);
      reset = 1'b1;
      #1;
      check_val("mr_rst_ctl",   {24'd0, ctl_a}, {24'd0, C_IDLE});
      check_val("mr_rst_stall", {28'd0, stall_cycles_a}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ex_muldiv_valid = 1'b0;
      cyc("mr_after", C_IDLE);
      set_load_use();
      cyc("mr_lu", C_LU);
      check_val("mr_lu_cnt", {28'd0, stall_cycles_a}, 32'd1);

      // Saturation: 20 consecutive load-use stall cycles.
      pulse_reset();
      set_load_use();
      for (int i = 0; i < 20; i++) @(negedge clk);
      check_val("sat_a", {28'd0, stall_cycles_a}, 32'd15);
      check_val("sat_b", {24'd0, stall_cycles_b}, 32'd20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
